add_seq_wide: RTL and testbench
===============================

Name: add_seq_wide

Overview:
- Multi-pass sequencer that wraps the 32-bit combinational adder.
- Upstream side: accepts wide operands over a valid/ready handshake, then drives the adder's a/b/ci one 32-bit word per cycle.
- Downstream side: captures each word's s/co from the adder, chains the carry into the next pass, and presents the registered wide result with carry and signed-overflow flags over a second valid/ready handshake.
- Supports add and subtract.

Parameters:
- NWORDS, 2, number of 32-bit passes; operand/result width W = 32*NWORDS; legal range 1..8.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A, unsigned or two's complement.
- in_b  input  W  operand B.
- in_sub  input  1  1 = compute A-B, 0 = A+B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  result.
- out_co  output  1  carry out of the MSB; for subtract, 1 = no borrow (A>=B unsigned).
- out_ovf  output  1  signed overflow.
- add_a  output  32  to adder a.
- add_b  output  32  to adder b.
- add_ci  output  1  to adder ci.
- add_s  input  32  from adder s.
- add_co  input  1  from adder co.

Behaviour:
- Reset (async assert, sync deassert by design upstream):
  - state=IDLE; all internal registers 0.
  - in_ready=1, out_valid=0, out_sum=0, out_co=0, out_ovf=0.
  - add_a=0, add_b=0, add_ci=0.
- Reset asserted mid-operation: in-flight operation and any unconsumed result are discarded; no partial output ever appears.
- State IDLE:
  - in_ready=1; add_* driven 0.
  - On in_valid&in_ready at an edge:
    - a_reg<=in_a.
    - b_reg<=in_sub ? ~in_b : in_b.
    - carry_reg<=in_sub.
    - idx<=0, go RUN.
- State RUN (in_ready=0, out_valid=0):
  - add_a = a_reg word idx (bits 32*idx+31 : 32*idx); add_b = b_reg word idx; add_ci = carry_reg. All combinational from registers.
  - Each edge:
    - sum_reg word idx <= add_s.
    - carry_reg <= add_co.
    - If idx==NWORDS-1: latch flags, go DONE; else idx<=idx+1.
  - Flags latched on the final pass:
    - out_co <= add_co.
    - out_ovf <= add_co XOR (a_reg[W-1] XOR b_reg[W-1] XOR add_s[31]), i.e. carry-in of MSB XOR carry-out of MSB. Uses the already-inverted b_reg.
- State DONE:
  - out_valid=1, in_ready=0; out_sum/out_co/out_ovf stable.
  - add_* driven 0.
  - On out_ready at an edge: go IDLE, out_valid falls.
  - in_valid in RUN/DONE is ignored, not queued.
- Latency:
  - Operands accepted at edge E; out_valid high after edge E+NWORDS.
  - With out_ready held high: result consumed at edge E+NWORDS+1, next accept possible at edge E+NWORDS+2.
  - Throughput one operation per NWORDS+2 cycles.
- Arithmetic:
  - Modulo 2^W; subtract computed as A + ~B + 1.
  - NWORDS=1 gives one RUN cycle.
  - Adder assumed purely combinational within one cycle.
- out_sum/out_co/out_ovf keep their last values in IDLE until overwritten by the next DONE.

Test Plan:
- NWORDS=2; add A=0x00000000_FFFFFFFF, B=0x1 -> out_sum=0x00000001_00000000, out_co=0, out_ovf=0; out_valid rises exactly 2 edges after accept; add_ci=1 observed on pass 1.
- Subtract A=0x0, B=0x1 -> out_sum=0xFFFFFFFF_FFFFFFFF, out_co=0 (borrow), out_ovf=0. Subtract A=5, B=5 -> sum 0, out_co=1.
- Signed overflow: A=0x7FFFFFFF_FFFFFFFF, B=1 add -> 0x80000000_00000000, out_ovf=1, out_co=0. A=B=0xFFFFFFFF_FFFFFFFF add -> sum 0xFFFFFFFF_FFFFFFFE, out_co=1, out_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> out_valid stays 1, out_sum unchanged, in_ready 0, new operands never accepted; release -> IDLE next edge.
- Reset: assert reset_n=0 asynchronously during pass 0 -> in_ready=1, out_valid=0, add_* =0 immediately; after release, a fresh add 3+4 yields 7.
- Back-to-back ops with out_ready tied 1: three operations issued as soon as in_ready allows -> results in order, spacing NWORDS+2 cycles; repeat with NWORDS=1 (spacing 3).

Source files
------------

// File: rtl/add_seq_wide.sv
// Multi-pass wide add/subtract sequencer around an external 32-bit combinational adder.
// Operands are taken once, fed to the adder a word per cycle LSW first, and the result is held until consumed.
module add_seq_wide #(
  parameter int NWORDS = 2,
  localparam int W = 32 * NWORDS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic          in_sub,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_co,
  output logic          out_ovf,
  output logic [31:0]   add_a,
  output logic [31:0]   add_b,
  output logic          add_ci,
  input  logic [31:0]   add_s,
  input  logic          add_co
);

  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      sum_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic              co_q;
  logic              ovf_q;
  logic              last_pass;

  assign last_pass = (idx_q == IDXW'(NWORDS - 1));

  // Adder inputs are forced to zero outside RUN so the shared adder sees no activity when idle.
  assign add_a  = (state_q == RUN) ? a_q[32*idx_q +: 32] : '0;
  assign add_b  = (state_q == RUN) ? b_q[32*idx_q +: 32] : '0;
  assign add_ci = (state_q == RUN) ? carry_q : 1'b0;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_co    = co_q;
  assign out_ovf   = ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            // Subtract is A + ~B + 1: invert B once here and seed the carry chain with 1.
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[32*idx_q +: 32] <= add_s;
          carry_q               <= add_co;
          if (last_pass) begin
            co_q    <= add_co;
            // Carry into the MSB recovered from the MSB sum bit; ovf is cin(MSB) ^ cout(MSB).
            ovf_q   <= add_co ^ (a_q[W-1] ^ b_q[W-1] ^ add_s[31]);
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_wide.sv
// Scoreboard bench for add_seq_wide: two instances (NWORDS=2 and NWORDS=1), each with a behavioural adder.
// Stimulus pushes expected results at acceptance; per-DUT monitors pop and compare on each output handshake.
module tb_add_seq_wide;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] sum;
    logic        co;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];

  // NWORDS=2 instance
  logic        v2, r2, sub2, ov2, ordy2, co2, ovf2, aci2, aco2;
  logic [63:0] a2, b2, sum2;
  logic [31:0] aa2, ab2, as2;
  assign {aco2, as2} = {1'b0, aa2} + {1'b0, ab2} + {32'd0, aci2};

  add_seq_wide #(.NWORDS(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v2), .in_ready(r2), .in_a(a2), .in_b(b2), .in_sub(sub2),
    .out_valid(ov2), .out_ready(ordy2), .out_sum(sum2), .out_co(co2), .out_ovf(ovf2),
    .add_a(aa2), .add_b(ab2), .add_ci(aci2), .add_s(as2), .add_co(aco2)
  );

  // NWORDS=1 instance
  logic        v1, r1, sub1, ov1, ordy1, co1, ovf1, aci1, aco1;
  logic [31:0] a1, b1, sum1;
  logic [31:0] aa1, ab1, as1;
  assign {aco1, as1} = {1'b0, aa1} + {1'b0, ab1} + {32'd0, aci1};

  add_seq_wide #(.NWORDS(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1), .in_sub(sub1),
    .out_valid(ov1), .out_ready(ordy1), .out_sum(sum1), .out_co(co1), .out_ovf(ovf1),
    .add_a(aa1), .add_b(ab1), .add_ci(aci1), .add_s(as1), .add_co(aco1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitors sample shortly after the falling edge, once stimulus for the next rising edge is settled.
  logic pv2 = 1'b0;
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (ov2 && !pv2) begin
        if (q2.size() == 0) chk("spurious_valid2", {63'd0, ov2}, 64'd0);
        else                chk("latency2", 64'(cyc - q2[0].acc), 64'd2);
      end
      if (ov2 && ordy2 && q2.size() > 0) begin
        exp_t e;
        e = q2.pop_front();
        $display("txn dut2: sum=%h co=%b ovf=%b (exp sum=%h co=%b ovf=%b)", sum2, co2, ovf2, e.sum, e.co, e.ovf);
        chk("sum2", sum2, e.sum);
        chk("co2", {63'd0, co2}, {63'd0, e.co});
        chk("ovf2", {63'd0, ovf2}, {63'd0, e.ovf});
      end
      pv2 <= ov2;
    end else begin
      pv2 <= 1'b0;
    end
  end

  logic pv1 = 1'b0;
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (ov1 && !pv1) begin
        if (q1.size() == 0) chk("spurious_valid1", {63'd0, ov1}, 64'd0);
        else                chk("latency1", 64'(cyc - q1[0].acc), 64'd1);
      end
      if (ov1 && ordy1 && q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        $display("txn dut1: sum=%h co=%b ovf=%b (exp sum=%h co=%b ovf=%b)", sum1, co1, ovf1, e.sum[31:0], e.co, e.ovf);
        chk("sum1", {32'd0, sum1}, e.sum);
        chk("co1", {63'd0, co1}, {63'd0, e.co});
        chk("ovf1", {63'd0, ovf1}, {63'd0, e.ovf});
      end
      pv1 <= ov1;
    end else begin
      pv1 <= 1'b0;
    end
  end

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic issue2(input logic [63:0] a, input logic [63:0] b, input logic sub,
                        input logic [63:0] es, input logic eco, input logic eovf, output int acc);
    int t = 0;
    acc = -1;
    v2 = 1'b1; a2 = a; b2 = b; sub2 = sub;
    while (!r2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!r2) begin
      chk("accept_timeout2", {63'd0, r2}, 64'd1);
    end else begin
      acc = cyc + 1;
      q2.push_back('{sum: es, co: eco, ovf: eovf, acc: acc});
      @(negedge clk);
    end
    v2 = 1'b0;
  endtask

  task automatic issue1(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] es, input logic eco, input logic eovf, output int acc);
    int t = 0;
    acc = -1;
    v1 = 1'b1; a1 = a; b1 = b; sub1 = sub;
    while (!r1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!r1) begin
      chk("accept_timeout1", {63'd0, r1}, 64'd1);
    end else begin
      acc = cyc + 1;
      q1.push_back('{sum: {32'd0, es}, co: eco, ovf: eovf, acc: acc});
      @(negedge clk);
    end
    v1 = 1'b0;
  endtask

  task automatic wait_idle2();
    int t = 0;
    while (!(r2 && q2.size() == 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("idle_timeout2", {63'd0, r2}, 64'd1);
  endtask

  int acc0, acc1, acc2;

  initial begin
    reset_n = 1'b0;
    v2 = 0; a2 = '0; b2 = '0; sub2 = 0; ordy2 = 1;
    v1 = 0; a1 = '0; b1 = '0; sub1 = 0; ordy1 = 1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, r2}, 64'd1);
    chk("rst_out_valid", {63'd0, ov2}, 64'd0);
    chk("rst_out_sum", sum2, 64'd0);
    chk("rst_flags", {62'd0, co2, ovf2}, 64'd0);
    chk("rst_add_io", {aa2, ab2} | {63'd0, aci2}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Carry across the word boundary; watch the adder inputs on both passes.
    issue2(64'h00000000_FFFFFFFF, 64'h1, 1'b0, 64'h00000001_00000000, 1'b0, 1'b0, acc0);
    chk("pass0_add_a", {32'd0, aa2}, 64'hFFFFFFFF);
    chk("pass0_add_ci", {63'd0, aci2}, 64'd0);
    @(negedge clk);
    chk("pass1_add_a", {32'd0, aa2}, 64'd0);
    chk("pass1_add_ci", {63'd0, aci2}, 64'd1);
    wait_idle2();

    issue2(64'h0, 64'h1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, acc0);
    issue2(64'h5, 64'h5, 1'b1, 64'h0, 1'b1, 1'b0, acc0);
    issue2(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 64'h80000000_00000000, 1'b0, 1'b1, acc0);
    issue2(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 1'b1, 1'b0, acc0);
    issue2(64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b0, 64'h22222222_22222211, 1'b0, 1'b0, acc0);
    issue2(64'h80000000_00000000, 64'h1, 1'b1, 64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1, acc0);
    wait_idle2();

    // Backpressure: result must hold and new operands must be refused.
    ordy2 = 1'b0;
    issue2(64'h100, 64'h200, 1'b0, 64'h300, 1'b0, 1'b0, acc0);
    begin
      int t = 0;
      while (!ov2 && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      v2 = i[0]; a2 = 64'hDEAD_0000 + 64'(i); b2 = 64'h1; sub2 = 1'b0;
      @(negedge clk);
      chk("bp_valid", {63'd0, ov2}, 64'd1);
      chk("bp_sum", sum2, 64'h300);
      chk("bp_in_ready", {63'd0, r2}, 64'd0);
    end
    v2 = 1'b0;
    ordy2 = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {63'd0, r2}, 64'd1);
    chk("bp_release_valid", {63'd0, ov2}, 64'd0);
    wait_idle2();

    // Asynchronous reset during pass 0 discards the operation.
    v2 = 1'b1; a2 = 64'h11111111_11111111; b2 = 64'h22222222_22222222; sub2 = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    v2 = 1'b0;
    #1;
    chk("arst_in_ready", {63'd0, r2}, 64'd1);
    chk("arst_out_valid", {63'd0, ov2}, 64'd0);
    chk("arst_add_io", {aa2, ab2} | {63'd0, aci2}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue2(64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0, acc0);
    wait_idle2();

    // Back-to-back with out_ready tied high: spacing NWORDS+2.
    issue2(64'd10, 64'd20, 1'b0, 64'd30, 1'b0, 1'b0, acc0);
    issue2(64'd100, 64'd1, 1'b1, 64'd99, 1'b1, 1'b0, acc1);
    issue2(64'hFFFFFFFF, 64'h1, 1'b0, 64'h1_00000000, 1'b0, 1'b0, acc2);
    chk("b2b_spacing2_a", 64'(acc1 - acc0), 64'd4);
    chk("b2b_spacing2_b", 64'(acc2 - acc1), 64'd4);
    wait_idle2();

    issue1(32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, acc0);
    issue1(32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1, acc1);
    issue1(32'h2, 32'h3, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, acc2);
    chk("b2b_spacing1_a", 64'(acc1 - acc0), 64'd3);
    chk("b2b_spacing1_b", 64'(acc2 - acc1), 64'd3);

    repeat (10) @(negedge clk);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
